// File: rtl/win3x3_gen_if.sv
// Pixel-stream / window bus between the raster source and the 3x3 window builder.
// master drives pixels and consumes windows; slave is the window builder.
interface win3x3_gen_if;
   logic        i_sof;
   logic        i_data_valid;
   logic [7:0]  i_data;
   logic        o_line_vaild;
   logic [23:0] o_line3_1;
   logic [23:0] o_line3_2;
   logic [23:0] o_line3_3;
   logic        o_frame_done;
   logic        o_sof_err;

   modport master (
      output i_sof,
      output i_data_valid,
      output i_data,
      input  o_line_vaild,
      input  o_line3_1,
      input  o_line3_2,
      input  o_line3_3,
      input  o_frame_done,
      input  o_sof_err
   );

   modport slave (
      input  i_sof,
      input  i_data_valid,
      input  i_data,
      output o_line_vaild,
      output o_line3_1,
      output o_line3_2,
      output o_line3_3,
      output o_frame_done,
      output o_sof_err
   );
endinterface

// File: rtl/win3x3_gen.sv
// 3x3 neighbourhood builder: two line buffers feed three shifting 24-bit row
// registers; a window is flagged valid only for interior pixels.
//
// state  | meaning
// IDLE   | waiting for a valid pixel with sof; other pixels are ignored
// ACTIVE | accepting every valid pixel of the current frame
module win3x3_gen #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input logic        clk,
   input logic        reset_n,
   win3x3_gen_if.slave pix
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [CW-1:0] COL_ONE  = CW'(1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] col, col_nxt, col_eff;
   logic [RW-1:0] row, row_nxt, row_eff;

   logic          accept;
   logic          last_pix;
   logic          frame_done_nxt;
   logic          sof_err_nxt;
   logic          win_valid_nxt;

   logic [7:0]    lb_a [IMG_W];
   logic [7:0]    lb_b [IMG_W];
   logic [7:0]    lb_a_rd;
   logic [7:0]    lb_b_rd;

   logic [23:0]   win_1;
   logic [23:0]   win_2;
   logic [23:0]   win_3;
   logic          line_vaild;
   logic          frame_done;
   logic          sof_err;

   // A valid sof always wins: the pixel is taken as (0,0) whatever the counters say,
   // which also makes a sof on the last pixel a restart rather than a frame end.
   always_comb begin
      accept         = 1'b0;
      col_eff        = col;
      row_eff        = row;
      state_nxt      = state;
      col_nxt        = col;
      row_nxt        = row;
      last_pix       = 1'b0;
      frame_done_nxt = 1'b0;
      sof_err_nxt    = 1'b0;
      win_valid_nxt  = 1'b0;

      if (pix.i_data_valid) begin
         if (pix.i_sof) begin
            accept      = 1'b1;
            col_eff     = '0;
            row_eff     = '0;
            sof_err_nxt = (state == ACTIVE) && ((col != '0) || (row != '0));
         end else if (state == ACTIVE) begin
            accept = 1'b1;
         end
      end

      if (accept) begin
         last_pix      = (row_eff == ROW_LAST) && (col_eff == COL_LAST);
         win_valid_nxt = (row_eff >= ROW_TWO) && (col_eff >= COL_TWO);
         if (last_pix) begin
            state_nxt      = IDLE;
            col_nxt        = '0;
            row_nxt        = '0;
            frame_done_nxt = 1'b1;
         end else begin
            state_nxt = ACTIVE;
            if (col_eff == COL_LAST) begin
               col_nxt = '0;
               row_nxt = row_eff + ROW_ONE;
            end else begin
               col_nxt = col_eff + COL_ONE;
               row_nxt = row_eff;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         col   <= '0;
         row   <= '0;
      end else begin
         state <= state_nxt;
         col   <= col_nxt;
         row   <= row_nxt;
      end
   end

   // Read-before-write: the old LB_A word moves down into LB_B as the new pixel lands.
   assign lb_a_rd = lb_a[col_eff];
   assign lb_b_rd = lb_b[col_eff];

   always_ff @(posedge clk) begin
      if (accept) begin
         lb_b[col_eff] <= lb_a_rd;
         lb_a[col_eff] <= pix.i_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         win_1      <= '0;
         win_2      <= '0;
         win_3      <= '0;
         line_vaild <= 1'b0;
         frame_done <= 1'b0;
         sof_err    <= 1'b0;
      end else begin
         line_vaild <= win_valid_nxt;
         frame_done <= frame_done_nxt;
         sof_err    <= sof_err_nxt;
         if (accept) begin
            win_1 <= {win_1[15:0], lb_b_rd};
            win_2 <= {win_2[15:0], lb_a_rd};
            win_3 <= {win_3[15:0], pix.i_data};
         end
      end
   end

   assign pix.o_line3_1    = win_1;
   assign pix.o_line3_2    = win_2;
   assign pix.o_line3_3    = win_3;
   assign pix.o_line_vaild = line_vaild;
   assign pix.o_frame_done = frame_done;
   assign pix.o_sof_err    = sof_err;

endmodule

// File: doc/win3x3_gen.md
Name: win3x3_gen

Overview:
- Builds a 3x3 pixel neighbourhood from a raster-order 8-bit pixel stream using two line buffers.
- Sits directly upstream of the 3x3 median filter in the DPC core.
- Presents each full window as three 24-bit row words plus a valid strobe.
- Emits windows only for interior pixels (no border padding): (IMG_W-2)*(IMG_H-2) windows per frame.

Parameters:
- IMG_W, 640, active pixels per line (>=3)
- IMG_H, 480, active lines per frame (>=3)

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- i_sof  input  1  start of frame; qualifies the first pixel of a frame; sampled only when i_data_valid=1
- i_data_valid  input  1  pixel qualifier; may deassert on any cycle (stall)
- i_data  input  8  unsigned pixel
- o_line_vaild  output  1  window valid strobe
- o_line3_1  output  24  row y-2, {col x-2, col x-1, col x}, MSB byte is the oldest column
- o_line3_2  output  24  row y-1, same packing
- o_line3_3  output  24  row y (current), same packing
- o_frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted
- o_sof_err  output  1  one-cycle pulse when i_sof arrives mid-frame

Behaviour:
- Reset is asynchronous, active-low. All outputs, counters, window registers and the FSM clear to 0/IDLE. Line-buffer contents are don't-care.
- Accept: a pixel is accepted on a rising edge with i_data_valid=1 in state ACTIVE, or with i_data_valid=1 and i_sof=1 in any state.
- Counters: col in 0..IMG_W-1 and row in 0..IMG_H-1, both $clog2-sized.
  - Each accept increments col.
  - col=IMG_W-1 wraps to 0 and increments row.
- FSM:
  - IDLE: pixels without i_sof are ignored (no counter or buffer update). Valid+sof: accept as (row0,col0) and go to ACTIVE.
  - ACTIVE: accept every valid pixel. Accept at (IMG_H-1, IMG_W-1): pulse o_frame_done, clear counters, go to IDLE.
  - ACTIVE + valid + sof at any position other than (0,0): pulse o_sof_err, restart at (0,0) with this pixel, stay ACTIVE.
- Line buffers: two IMG_W x 8 memories, LB_A (row y-1) and LB_B (row y-2), both addressed by col. On each accept:
  - Read LB_A[col] and LB_B[col] with read-before-write (old data).
  - Write LB_B[col] <= old LB_A[col].
  - Write LB_A[col] <= i_data.
- Window registers:
  - On each accept, each 24-bit row register shifts left by 8 and loads a new LSB byte: LB_B[col] into row 1, LB_A[col] into row 2, i_data into row 3.
  - o_line3_* are these registers directly.
  - They hold their value while no pixel is accepted.
- Valid and latency:
  - o_line_vaild <= accept AND row>=2 AND col>=2, evaluated on the pre-increment counters. It is registered in the same edge as the window registers.
  - Latency: a pixel presented in cycle t produces its window and strobe visible in cycle t+1.
  - o_line_vaild is low on any cycle following a non-accept (stall gaps propagate).
- Rows 0/1 and cols 0/1 never assert valid. Stale line-buffer data from a previous frame must not leak into a valid window.
- Simultaneous events: a last-pixel accept with i_sof=1 is treated as sof (error pulse, restart). In that case o_frame_done does not pulse.
- o_frame_done and o_sof_err are registered single-cycle pulses, asserted in cycle t+1.
- Widths: pure data movement, no arithmetic on pixels.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> all outputs 0. Release, then drive pixels without sof -> no o_line_vaild, counters unchanged.
- Basic frame, IMG_W=4, IMG_H=4, pixel = row*16+col, continuous valid:
  - First o_line_vaild occurs 1 cycle after pixel (2,2) with o_line3_1=0x000102, o_line3_2=0x101112, o_line3_3=0x202122.
  - Exactly 4 valid windows per frame; the last is 0x111213/0x212223/0x313233.
  - o_frame_done pulses once, 1 cycle after pixel (3,3).
- Stalls: same frame with i_data_valid randomly low 50% of cycles -> identical window sequence and values. o_line_vaild is never high in a cycle following a non-accept.
- Back-to-back frames (second frame pixel = 0x80+row*16+col) -> second frame's first window is 0x808182/0x909192/0xA0A1A2, with no stale frame-1 bytes.
- Mid-frame sof at (2,1) -> o_sof_err pulse, no o_frame_done. Restart at (0,0), and a subsequent full frame yields the 4 correct windows.
- Reset asserted mid-frame at (2,3) -> outputs clear immediately. After release, a fresh sof frame yields correct windows.
